// File: rtl/discharge_seq_pkg.sv
// Shared definitions for the discharge profile sequencer.
package discharge_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Cycles the core is held in reset while a profile is loaded
  localparam int unsigned LOAD_HOLD  = 2;
  localparam int unsigned LOAD_CNT_W = $clog2(LOAD_HOLD);

endpackage

// File: rtl/discharge_profile_ram.sv
// Small profile table: one synchronous write port, asynchronous read by index.
module discharge_profile_ram #(
  parameter int unsigned C_IDX_WIDTH   = 2,
  parameter int unsigned C_ENTRY_WIDTH = 144
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_wr,
  input  logic [C_IDX_WIDTH-1:0]   i_wr_idx,
  input  logic [C_ENTRY_WIDTH-1:0] i_wr_data,
  input  logic [C_IDX_WIDTH-1:0]   i_rd_idx,
  output logic [C_ENTRY_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 2 ** C_IDX_WIDTH;

  logic [C_ENTRY_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/discharge_seq.sv
// Plays a range of discharge profiles through the PWM core with repeats and
// inter-profile gaps; supports start/abort from the CPU register block.
module discharge_seq
  import discharge_seq_pkg::*;
#(
  parameter int unsigned C_PWM_CNT_WIDTH    = 16,
  parameter int unsigned C_FRACTIONAL_WIDTH = 16,
  parameter int unsigned C_NUMBER_WIDTH     = 32,
  parameter int unsigned C_IDX_WIDTH        = 2,
  parameter int unsigned C_GAP_WIDTH        = 16,
  parameter int unsigned C_REPEAT_WIDTH     = 8
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic                                        cfg_wr,
  input  logic [C_IDX_WIDTH-1:0]                      cfg_idx,
  input  logic [C_PWM_CNT_WIDTH-1:0]                  cfg_denominator,
  input  logic [C_PWM_CNT_WIDTH-1:0]                  cfg_numerator0,
  input  logic [C_PWM_CNT_WIDTH-1:0]                  cfg_numerator1,
  input  logic [C_NUMBER_WIDTH-1:0]                   cfg_number0,
  input  logic [C_NUMBER_WIDTH-1:0]                   cfg_number1,
  input  logic [C_PWM_CNT_WIDTH+C_FRACTIONAL_WIDTH-1:0] cfg_inc0,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic [C_IDX_WIDTH-1:0]                      first_idx,
  input  logic [C_IDX_WIDTH-1:0]                      last_idx,
  input  logic [C_REPEAT_WIDTH-1:0]                   repeat_num,
  input  logic [C_GAP_WIDTH-1:0]                      gap_cycles,
  output logic                                        core_resetn,
  output logic [C_PWM_CNT_WIDTH-1:0]                  core_denominator,
  output logic [C_PWM_CNT_WIDTH-1:0]                  core_numerator0,
  output logic [C_PWM_CNT_WIDTH-1:0]                  core_numerator1,
  output logic [C_NUMBER_WIDTH-1:0]                   core_number0,
  output logic [C_NUMBER_WIDTH-1:0]                   core_number1,
  output logic [C_PWM_CNT_WIDTH+C_FRACTIONAL_WIDTH-1:0] core_inc0,
  input  logic                                        core_done,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        aborted,
  output logic [C_IDX_WIDTH-1:0]                      cur_idx
);

  localparam int unsigned INC_W   = C_PWM_CNT_WIDTH + C_FRACTIONAL_WIDTH;
  localparam int unsigned ENTRY_W = 3 * C_PWM_CNT_WIDTH + 2 * C_NUMBER_WIDTH + INC_W;

  state_t                       r_state;
  logic [LOAD_CNT_W-1:0]        r_load_cnt;
  logic [C_GAP_WIDTH-1:0]       r_gap_cnt;
  logic [C_GAP_WIDTH-1:0]       r_gap;
  logic [C_REPEAT_WIDTH-1:0]    r_rep;
  logic [C_IDX_WIDTH-1:0]       r_first;
  logic [C_IDX_WIDTH-1:0]       r_last;
  logic [C_IDX_WIDTH-1:0]       r_cur_idx;
  logic                         r_core_resetn;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_aborted;
  logic [C_PWM_CNT_WIDTH-1:0]   r_den;
  logic [C_PWM_CNT_WIDTH-1:0]   r_num0;
  logic [C_PWM_CNT_WIDTH-1:0]   r_num1;
  logic [C_NUMBER_WIDTH-1:0]    r_number0;
  logic [C_NUMBER_WIDTH-1:0]    r_number1;
  logic [INC_W-1:0]             r_inc0;

  logic [ENTRY_W-1:0]           w_wr_data;
  logic [ENTRY_W-1:0]           w_rd_data;
  logic                         w_range_end;

  assign w_wr_data = {cfg_denominator, cfg_numerator0, cfg_numerator1,
                      cfg_number0, cfg_number1, cfg_inc0};

  discharge_profile_ram #(
    .C_IDX_WIDTH   (C_IDX_WIDTH),
    .C_ENTRY_WIDTH (ENTRY_W)
  ) u_ram (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr      (cfg_wr),
    .i_wr_idx  (cfg_idx),
    .i_wr_data (w_wr_data),
    .i_rd_idx  (r_cur_idx),
    .o_rd_data (w_rd_data)
  );

  assign w_range_end = (r_cur_idx == r_last);

  // Sequencer FSM; abort from any active state overrides every other event
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_load_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_gap         <= '0;
      r_rep         <= '0;
      r_first       <= '0;
      r_last        <= '0;
      r_cur_idx     <= '0;
      r_core_resetn <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_den         <= '0;
      r_num0        <= '0;
      r_num1        <= '0;
      r_number0     <= '0;
      r_number1     <= '0;
      r_inc0        <= '0;
    end else if (r_state != ST_IDLE && abort) begin
      r_state       <= ST_IDLE;
      r_core_resetn <= 1'b0;
      r_busy        <= 1'b0;
      r_aborted     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_first    <= first_idx;
            r_last     <= last_idx;
            r_rep      <= (repeat_num == '0) ? C_REPEAT_WIDTH'(1) : repeat_num;
            r_gap      <= gap_cycles;
            r_cur_idx  <= first_idx;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_busy     <= 1'b1;
            r_load_cnt <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_load_cnt == '0) begin
            {r_den, r_num0, r_num1, r_number0, r_number1, r_inc0} <= w_rd_data;
          end
          if (r_load_cnt == LOAD_CNT_W'(LOAD_HOLD - 1)) begin
            r_core_resetn <= 1'b1;
            r_state       <= ST_RUN;
          end else begin
            r_load_cnt <= r_load_cnt + LOAD_CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (core_done) begin
            r_core_resetn <= 1'b0;
            if (w_range_end && r_rep == C_REPEAT_WIDTH'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              if (w_range_end) begin
                r_cur_idx <= r_first;
                r_rep     <= r_rep - C_REPEAT_WIDTH'(1);
              end else begin
                r_cur_idx <= r_cur_idx + C_IDX_WIDTH'(1);
              end
              r_load_cnt <= '0;
              r_gap_cnt  <= C_GAP_WIDTH'(1);
              r_state    <= (r_gap == '0) ? ST_LOAD : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt >= r_gap) begin
            r_load_cnt <= '0;
            r_state    <= ST_LOAD;
          end else begin
            r_gap_cnt <= r_gap_cnt + C_GAP_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_resetn      = r_core_resetn;
  assign core_denominator = r_den;
  assign core_numerator0  = r_num0;
  assign core_numerator1  = r_num1;
  assign core_number0     = r_number0;
  assign core_number1     = r_number1;
  assign core_inc0        = r_inc0;
  assign busy             = r_busy;
  assign done             = r_done;
  assign aborted          = r_aborted;
  assign cur_idx          = r_cur_idx;

endmodule

// File: tb/tb_discharge_seq.sv
// Bench for discharge_seq: expected profile loads are queued at start and
// checked each time the core is released from reset.
module tb_discharge_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_denominator = '0;
  logic [15:0] cfg_numerator0 = '0;
  logic [15:0] cfg_numerator1 = '0;
  logic [31:0] cfg_number0 = '0;
  logic [31:0] cfg_number1 = '0;
  logic [31:0] cfg_inc0 = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  first_idx = '0;
  logic [1:0]  last_idx = '0;
  logic [7:0]  repeat_num = '0;
  logic [15:0] gap_cycles = '0;
  logic        core_resetn;
  logic [15:0] core_denominator, core_numerator0, core_numerator1;
  logic [31:0] core_number0, core_number1, core_inc0;
  logic        core_done = 1'b0;
  logic        busy, done, aborted;
  logic [1:0]  cur_idx;

  always #5 clk = ~clk;

  discharge_seq dut (
    .clk(clk), .resetn(resetn),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_denominator(cfg_denominator),
    .cfg_numerator0(cfg_numerator0), .cfg_numerator1(cfg_numerator1),
    .cfg_number0(cfg_number0), .cfg_number1(cfg_number1), .cfg_inc0(cfg_inc0),
    .start(start), .abort(abort), .first_idx(first_idx), .last_idx(last_idx),
    .repeat_num(repeat_num), .gap_cycles(gap_cycles),
    .core_resetn(core_resetn), .core_denominator(core_denominator),
    .core_numerator0(core_numerator0), .core_numerator1(core_numerator1),
    .core_number0(core_number0), .core_number1(core_number1), .core_inc0(core_inc0),
    .core_done(core_done), .busy(busy), .done(done), .aborted(aborted),
    .cur_idx(cur_idx)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] den;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] den_m[4];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic write_entry(input logic [1:0] idx, input logic [15:0] den);
    cfg_idx         = idx;
    cfg_denominator = den;
    cfg_numerator0  = den - 16'd2;
    cfg_numerator1  = 16'd2;
    cfg_number0     = 32'd3;
    cfg_number1     = 32'd4;
    cfg_inc0        = 32'h0001_0000;
    cfg_wr          = 1'b1;
    @(negedge clk);
    cfg_wr          = 1'b0;
    den_m[idx]      = den;
  endtask

  task automatic start_seq(input logic [1:0] f, input logic [1:0] l,
                           input logic [7:0] rep, input logic [15:0] gap);
    first_idx  = f;
    last_idx   = l;
    repeat_num = rep;
    gap_cycles = gap;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    first_idx  = ~f;
    last_idx   = ~l;
    repeat_num = 8'd7;
    gap_cycles = 16'd1;
  endtask

  task automatic push_one(input logic [1:0] idx, input logic [15:0] den);
    exp_t e;
    e.idx = idx;
    e.den = den;
    exp_q.push_back(e);
  endtask

  task automatic push_range(input logic [1:0] f, input logic [1:0] l, input int rep);
    logic [1:0] i;
    int r;
    i = f;
    r = (rep == 0) ? 1 : rep;
    for (int g = 0; g < 64; g++) begin
      push_one(i, den_m[i]);
      if (i == l) begin
        if (r == 1) break;
        r--;
        i = f;
      end else begin
        i = i + 2'd1;
      end
    end
  endtask

  // Wait for the core to be released, then score the loaded profile
  task automatic wait_load(output int low);
    exp_t e;
    low = 0;
    while (core_resetn !== 1'b1 && low < 200) begin
      low++;
      @(negedge clk);
    end
    n_cmp++;
    if (core_resetn !== 1'b1) begin
      $display("FAIL load_timeout: core_resetn=%b after %0d cycles, want 1", core_resetn, low);
      n_err++;
      low = -1;
    end else if (exp_q.size() == 0) begin
      $display("FAIL unexpected_load: idx=%0d den=%0d, scoreboard empty", cur_idx, core_denominator);
      n_err++;
    end else begin
      e = exp_q.pop_front();
      if (cur_idx !== e.idx || core_denominator !== e.den) begin
        $display("FAIL load_profile: idx=%0d den=%0d want idx=%0d den=%0d",
                 cur_idx, core_denominator, e.idx, e.den);
        n_err++;
      end
    end
  endtask

  task automatic finish_profile();
    repeat (2) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({core_resetn, busy, done, aborted} !== 4'b0000) begin
      $display("FAIL reset_flags: resetn/busy/done/aborted=%b want 0000",
               {core_resetn, busy, done, aborted});
      n_err++;
    end
    n_cmp++;
    if (cur_idx !== 2'd0 || core_denominator !== 16'd0 || core_inc0 !== 32'd0) begin
      $display("FAIL reset_params: idx=%0d den=%0d inc0=%0h want 0", cur_idx, core_denominator, core_inc0);
      n_err++;
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int low;
    write_entry(2'd0, 16'd10);
    for (int i = 1; i < 4; i++) write_entry(2'(i), 16'(20 + i));
    push_range(2'd0, 2'd0, 1);
    start_seq(2'd0, 2'd0, 8'd1, 16'd0);
    wait_load(low);
    n_cmp++;
    if (low + 1 !== 3) begin
      $display("FAIL start_latency: %0d cycles want 3", low + 1);
      n_err++;
    end
    n_cmp++;
    if (core_numerator0 !== 16'd8 || core_numerator1 !== 16'd2 || core_number0 !== 32'd3 ||
        core_number1 !== 32'd4 || core_inc0 !== 32'h0001_0000) begin
      $display("FAIL single_params: n0=%0d n1=%0d num0=%0d num1=%0d inc0=%0h want 8 2 3 4 10000",
               core_numerator0, core_numerator1, core_number0, core_number1, core_inc0);
      n_err++;
    end
    finish_profile();
    n_cmp++;
    if ({busy, done, core_resetn} !== 3'b010) begin
      $display("FAIL single_done: busy/done/resetn=%b want 010", {busy, done, core_resetn});
      n_err++;
    end
  endtask

  task automatic test_wrap();
    int low;
    push_range(2'd3, 2'd1, 1);
    start_seq(2'd3, 2'd1, 8'd1, 16'd5);
    for (int k = 0; k < 3; k++) begin
      wait_load(low);
      if (k > 0) begin
        n_cmp++;
        if (low !== 7) begin
          $display("FAIL wrap_gap: core reset low %0d cycles want 7", low);
          n_err++;
        end
      end
      finish_profile();
    end
    n_cmp++;
    if ({busy, done, cur_idx} !== 4'b0101) begin
      $display("FAIL wrap_end: busy/done/idx=%b want 0101", {busy, done, cur_idx});
      n_err++;
    end
  endtask

  task automatic test_repeat();
    int low;
    push_range(2'd0, 2'd1, 3);
    start_seq(2'd0, 2'd1, 8'd3, 16'd0);
    for (int k = 0; k < 6; k++) begin
      wait_load(low);
      if (k == 3) begin
        n_cmp++;
        if (low !== 2) begin
          $display("FAIL repeat_nogap: core reset low %0d cycles want 2", low);
          n_err++;
        end
      end
      finish_profile();
    end
    push_range(2'd0, 2'd1, 0);
    start_seq(2'd0, 2'd1, 8'd0, 16'd0);
    for (int k = 0; k < 2; k++) begin
      wait_load(low);
      finish_profile();
    end
    n_cmp++;
    if ({busy, done} !== 2'b01 || exp_q.size() != 0) begin
      $display("FAIL repeat_end: busy/done=%b pending=%0d want 01 and 0", {busy, done}, exp_q.size());
      n_err++;
    end
  endtask

  task automatic test_busy_cfg();
    int low;
    logic [15:0] old0;
    old0 = den_m[0];
    push_one(2'd0, old0);
    push_one(2'd1, den_m[1]);
    push_one(2'd0, 16'd99);
    push_one(2'd1, den_m[1]);
    start_seq(2'd0, 2'd1, 8'd2, 16'd2);
    wait_load(low);
    start_seq(2'd2, 2'd3, 8'd1, 16'd0);
    write_entry(2'd0, 16'd99);
    n_cmp++;
    if (core_denominator !== old0 || cur_idx !== 2'd0 || core_resetn !== 1'b1) begin
      $display("FAIL cfg_during_run: den=%0d idx=%0d resetn=%b want %0d 0 1",
               core_denominator, cur_idx, core_resetn, old0);
      n_err++;
    end
    finish_profile();
    for (int k = 0; k < 3; k++) begin
      wait_load(low);
      finish_profile();
    end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      $display("FAIL busy_cfg_end: busy/done=%b want 01", {busy, done});
      n_err++;
    end
  endtask

  task automatic test_abort();
    int low;
    push_one(2'd0, den_m[0]);
    start_seq(2'd0, 2'd1, 8'd1, 16'd0);
    wait_load(low);
    core_done = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    abort     = 1'b0;
    n_cmp++;
    if ({busy, aborted, done, core_resetn} !== 4'b0100) begin
      $display("FAIL abort_flags: busy/aborted/done/resetn=%b want 0100",
               {busy, aborted, done, core_resetn});
      n_err++;
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (core_resetn !== 1'b0 || busy !== 1'b0 || cur_idx !== 2'd0) begin
      $display("FAIL abort_no_reload: resetn=%b busy=%b idx=%0d want 0 0 0", core_resetn, busy, cur_idx);
      n_err++;
    end
  endtask

  task automatic test_async_reset();
    int low;
    push_one(2'd0, den_m[0]);
    start_seq(2'd0, 2'd1, 8'd1, 16'd20);
    n_cmp++;
    if (aborted !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL start_clears: aborted=%b busy=%b want 0 1", aborted, busy);
      n_err++;
    end
    wait_load(low);
    finish_profile();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || core_resetn !== 1'b0 || cur_idx !== 2'd1) begin
      $display("FAIL gap_state: busy=%b resetn=%b idx=%0d want 1 0 1", busy, core_resetn, cur_idx);
      n_err++;
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, aborted, core_resetn} !== 4'b0000 || cur_idx !== 2'd0 ||
        core_denominator !== 16'd0) begin
      $display("FAIL async_reset: busy/done/aborted/resetn=%b idx=%0d den=%0d want 0000 0 0",
               {busy, done, aborted, core_resetn}, cur_idx, core_denominator);
      n_err++;
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) den_m[i] = 16'd0;
    @(negedge clk);
    push_range(2'd2, 2'd2, 1);
    start_seq(2'd2, 2'd2, 8'd1, 16'd0);
    wait_load(low);
    finish_profile();
    n_cmp++;
    if ({busy, done} !== 2'b01 || exp_q.size() != 0) begin
      $display("FAIL table_reset_end: busy/done=%b pending=%0d want 01 and 0", {busy, done}, exp_q.size());
      n_err++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) den_m[i] = 16'd0;
    test_reset();
    test_single();
    test_wrap();
    test_repeat();
    test_busy_cfg();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
